// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the MM:SS BCD countdown timer.
// State encodings are visible on the controller's state port.
package bcd_timer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADED = 3'd1,
        RUN    = 3'd2,
        PAUSE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    // Out-of-range digits are forced to zero rather than clamped.
    function automatic logic [3:0] bcd_sanitise(input logic [3:0] nibble, input logic [3:0] max);
        return (nibble > max) ? 4'd0 : nibble;
    endfunction

endpackage

// File: rtl/bcd_countdown_ctrl_digit.sv
// One decimal down-counting digit; wraps 0 -> MAX and reports a borrow.
module bcd_digit_down #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec_en,
    output logic [3:0] q,
    output logic       borrow_out
);

    // Digit register: load has priority over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 4'd0;
        end else if (load) begin
            q <= load_val;
        end else if (dec_en) begin
            q <= (q == 4'd0) ? MAX : (q - 4'd1);
        end else begin
            q <= q;
        end
    end

    assign borrow_out = dec_en && (q == 4'd0);

endmodule

// File: rtl/bcd_countdown_ctrl.sv
// Command FSM, tick prescaler and borrow chain for a 4-digit MM:SS countdown.
// time_bcd packing: {min_tens, min_ones, sec_tens, sec_ones}.
module bcd_countdown_ctrl
    import bcd_timer_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int PW       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic        start,
    input  logic        pause,
    input  logic [15:0] preset_bcd,
    output logic [15:0] time_bcd,
    output logic [2:0]  state,
    output logic        running,
    output logic        done
);

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_t        state_r, state_nx_s;
    logic [PW-1:0] presc_r, presc_nx_s;
    logic          done_r, done_nx_s;
    logic          running_r;
    logic          dig_load_s;
    logic [15:0]   load_val_s;
    logic [15:0]   time_s;
    logic          tick_s;
    logic [3:0]    dec_en_s;
    logic [3:0]    borrow_s;

    // A tick needs RUN with no overriding command and a non-zero time, so 00:00 never wraps.
    assign tick_s = (state_r == RUN) && !clear && !pause &&
                    (presc_r == TICK_LAST) && (time_s != 16'h0000);

    assign dec_en_s = {borrow_s[2:0], tick_s};

    for (genvar i = 0; i < 4; i++) begin : g_dig
        bcd_digit_down #(
            .MAX ((i == 1) ? SEC_TENS_MAX : DIGIT_MAX)
        ) u_dig (
            .clk        (clk),
            .rst        (rst),
            .load       (dig_load_s),
            .load_val   (load_val_s[i*4 +: 4]),
            .dec_en     (dec_en_s[i]),
            .q          (time_s[i*4 +: 4]),
            .borrow_out (borrow_s[i])
        );
    end

    // Next-state, prescaler and digit-load decode; priority clear > load > pause > start.
    always_comb begin
        state_nx_s = state_r;
        presc_nx_s = presc_r;
        done_nx_s  = 1'b0;
        dig_load_s = 1'b0;
        load_val_s = 16'h0000;
        if (clear) begin
            state_nx_s = IDLE;
            presc_nx_s = '0;
            dig_load_s = 1'b1;
        end else if (state_r > DONE) begin
            state_nx_s = IDLE;
        end else if (load && (state_r != RUN)) begin
            state_nx_s = LOADED;
            presc_nx_s = '0;
            dig_load_s = 1'b1;
            load_val_s = {bcd_sanitise(preset_bcd[15:12], DIGIT_MAX),
                          bcd_sanitise(preset_bcd[11:8],  DIGIT_MAX),
                          bcd_sanitise(preset_bcd[7:4],   SEC_TENS_MAX),
                          bcd_sanitise(preset_bcd[3:0],   DIGIT_MAX)};
        end else begin
            case (state_r)
                RUN: begin
                    if (pause) begin
                        state_nx_s = PAUSE;
                    end else if (presc_r == TICK_LAST) begin
                        presc_nx_s = '0;
                        // A borrow out of min_tens would mean underflow; treat it as expiry too.
                        if ((time_s == 16'h0001) || (time_s == 16'h0000) || borrow_s[3]) begin
                            state_nx_s = DONE;
                            done_nx_s  = 1'b1;
                        end else begin
                            state_nx_s = RUN;
                        end
                    end else begin
                        presc_nx_s = presc_r + PW'(1);
                    end
                end
                LOADED: begin
                    if (start && (time_s != 16'h0000)) begin
                        state_nx_s = RUN;
                        presc_nx_s = '0;
                    end else if (start) begin
                        state_nx_s = DONE;
                        done_nx_s  = 1'b1;
                    end else begin
                        state_nx_s = LOADED;
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_nx_s = RUN;
                    end else begin
                        state_nx_s = PAUSE;
                    end
                end
                IDLE:    state_nx_s = IDLE;
                DONE:    state_nx_s = DONE;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // State, prescaler and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            presc_r   <= '0;
            done_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            presc_r   <= presc_nx_s;
            done_r    <= done_nx_s;
            running_r <= (state_nx_s == RUN);
        end
    end

    assign time_bcd = time_s;
    assign state    = state_r;
    assign running  = running_r;
    assign done     = done_r;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Directed bench for bcd_countdown_ctrl with TICK_DIV=4.
module tb_bcd_countdown_ctrl;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        load;
    logic        start;
    logic        pause;
    logic [15:0] preset_bcd;
    logic [15:0] time_bcd;
    logic [2:0]  state;
    logic        running;
    logic        done;

    int checks_cnt;
    int errors_cnt;

    bcd_countdown_ctrl #(
        .TICK_DIV (4),
        .PW       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .load       (load),
        .start      (start),
        .pause      (pause),
        .preset_bcd (preset_bcd),
        .time_bcd   (time_bcd),
        .state      (state),
        .running    (running),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Advance n clock edges; outputs settle 1 time unit after the edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] val);
        preset_bcd = val;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    logic [15:0] exp_seq [3];

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b1; clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        preset_bcd = 16'h0000;
        cyc(1);
        rst = 1'b0;
        chk("rst_time", time_bcd, 16'h0000);
        chk("rst_state", {13'd0, state}, 16'd0);
        chk("rst_running", {15'd0, running}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);

        // 00:03 countdown to expiry
        do_load(16'h0003);
        chk("ld3_time", time_bcd, 16'h0003);
        chk("ld3_state", {13'd0, state}, 16'd1);
        do_start();
        chk("run_state", {13'd0, state}, 16'd2);
        chk("run_running", {15'd0, running}, 16'd1);
        exp_seq[0] = 16'h0002; exp_seq[1] = 16'h0001; exp_seq[2] = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            cyc(3);
            chk("hold_between_ticks", time_bcd, (k == 0) ? 16'h0003 : exp_seq[k-1]);
            cyc(1);
            chk("tick_time", time_bcd, exp_seq[k]);
        end
        chk("exp_state", {13'd0, state}, 16'd4);
        chk("exp_done", {15'd0, done}, 16'd1);
        chk("exp_running", {15'd0, running}, 16'd0);
        cyc(1);
        chk("exp_done_drop", {15'd0, done}, 16'd0);
        chk("exp_state_hold", {13'd0, state}, 16'd4);
        chk("exp_no_wrap", time_bcd, 16'h0000);

        // full borrow chain 10:00 -> 09:59
        do_clear();
        chk("clr_state", {13'd0, state}, 16'd0);
        do_load(16'h1000);
        do_start();
        cyc(3);
        chk("borrow_pre", time_bcd, 16'h1000);
        cyc(1);
        chk("borrow_chain", time_bcd, 16'h0959);

        // pause holds the partial second
        do_clear();
        do_load(16'h0010);
        do_start();
        cyc(6);
        chk("pz_time", time_bcd, 16'h0009);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        chk("pz_state", {13'd0, state}, 16'd3);
        chk("pz_running", {15'd0, running}, 16'd0);
        cyc(20);
        chk("pz_hold_time", time_bcd, 16'h0009);
        chk("pz_hold_state", {13'd0, state}, 16'd3);
        do_start();
        chk("resume_state", {13'd0, state}, 16'd2);
        cyc(1);
        chk("resume_partial", time_bcd, 16'h0009);
        cyc(1);
        chk("resume_tick", time_bcd, 16'h0008);

        // sanitising load and zero-time start
        do_clear();
        do_load(16'hFA7C);
        chk("san_time", time_bcd, 16'h0000);
        chk("san_state", {13'd0, state}, 16'd1);
        do_start();
        chk("zero_start_state", {13'd0, state}, 16'd4);
        chk("zero_start_done", {15'd0, done}, 16'd1);
        preset_bcd = 16'h0003;
        load = 1'b1; start = 1'b1;
        cyc(1);
        load = 1'b0; start = 1'b0;
        chk("ld_beats_start_state", {13'd0, state}, 16'd1);
        chk("ld_beats_start_time", time_bcd, 16'h0003);

        // load ignored in RUN, clear beats start
        do_clear();
        do_load(16'h0005);
        do_start();
        do_load(16'h0030);
        chk("run_ld_ignored_time", time_bcd, 16'h0005);
        chk("run_ld_ignored_state", {13'd0, state}, 16'd2);
        clear = 1'b1; start = 1'b1;
        cyc(1);
        clear = 1'b0; start = 1'b0;
        chk("clr_wins_time", time_bcd, 16'h0000);
        chk("clr_wins_state", {13'd0, state}, 16'd0);
        chk("clr_wins_running", {15'd0, running}, 16'd0);

        // reset during RUN
        do_load(16'h0001);
        do_start();
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rrun_time", time_bcd, 16'h0000);
        chk("rrun_state", {13'd0, state}, 16'd0);
        chk("rrun_running", {15'd0, running}, 16'd0);
        chk("rrun_done", {15'd0, done}, 16'd0);
        cyc(3);
        chk("rrun_done_later", {15'd0, done}, 16'd0);
        chk("rrun_state_later", {13'd0, state}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_ctrl.md
Name: bcd_countdown_ctrl

Overview:
- Controller/sequencer for a 4-digit BCD countdown timer (MM:SS, max 99:59) built from cascaded decimal down-counters.
- Owns the command FSM (load/start/pause/clear), the tick prescaler, and the digit borrow chain.
- Raises a one-cycle `done` pulse when the count reaches 00:00.
- Sits between a user/CPU command interface and display logic: the next layer above the decimal counter datapath.

Parameters:
- TICK_DIV, 10, number of clk cycles per count tick (1 s in silicon, small in simulation); legal range 2..65535.
- PW, 16, prescaler counter width; must satisfy 2^PW >= TICK_DIV.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- clear  input  1  level-sampled command: zero time, go to IDLE.
- load  input  1  level-sampled command: capture preset_bcd.
- start  input  1  level-sampled command: begin or resume counting.
- pause  input  1  level-sampled command: suspend counting.
- preset_bcd  input  16  {min_tens, min_ones, sec_tens, sec_ones}, BCD nibbles.
- time_bcd  output  16  current time, same packing as preset_bcd.
- state  output  3  FSM state encoding (see package).
- running  output  1  high while state == RUN.
- done  output  1  one-cycle pulse on expiry.

Behaviour:
- Reset (rst=1 at a clk edge):
  - time_bcd = 16'h0000, state = IDLE, running = 0, done = 0, prescaler = 0.
  - rst overrides all commands.
- FSM states: IDLE=0, LOADED=1, RUN=2, PAUSE=3, DONE=4. Encodings 5–7 are illegal and recover to IDLE on the next edge.
- Command priority per cycle: clear > load > pause > start.
- clear, any state:
  - time_bcd = 0, prescaler = 0, next state IDLE.
- load, accepted in IDLE/LOADED/PAUSE/DONE, ignored in RUN:
  - Each nibble is sanitised: ones digits > 9 become 0; sec_tens > 5 becomes 0; min_tens > 9 becomes 0.
  - Sanitised value goes to time_bcd next edge; prescaler = 0; next state LOADED.
- start:
  - LOADED with time != 0: go to RUN, prescaler = 0.
  - LOADED with time == 0: go to DONE, and done pulses.
  - PAUSE: go to RUN; prescaler keeps its held value (no restart of the partial second).
  - IDLE and DONE: start is ignored.
- pause in RUN: go to PAUSE; prescaler and time_bcd freeze. Ignored in other states.
- start and pause together in RUN: pause wins.
- Prescaler:
  - Increments only in RUN.
  - When prescaler == TICK_DIV-1 it wraps to 0 and generates an internal tick.
  - First tick comes exactly TICK_DIV cycles after the RUN-entry edge.
- On tick, time_bcd decrements by one second:
  - sec_ones 0 -> 9 with borrow.
  - sec_tens 0 -> 5 with borrow.
  - min_ones 0 -> 9 with borrow.
  - min_tens decrements on borrow.
  - Example: 10:00 -> 09:59.
- Expiry:
  - A tick while time_bcd == 00:01 makes time 00:00 and state DONE on the same edge.
  - done = 1 for exactly that following cycle.
  - time_bcd never wraps below 00:00.
- done is registered. It is high only in the first cycle after entering DONE.
- running = (state == RUN), registered alongside state.
- Reset during RUN: next edge returns to reset values, with no done pulse.

Decomposition:
- Package bcd_timer_pkg:
  - state enum/localparams IDLE..DONE.
  - localparams SEC_TENS_MAX=5, DIGIT_MAX=9.
  - function bcd_sanitise(nibble, max).
- Sub-module bcd_digit_down:
  - One decimal digit with parameter MAX.
  - Ports: clk, rst, load, load_val, dec_en, q[3:0], borrow_out (asserted when dec_en and q==0).
  - Four instances chained via borrow -> dec_en.
- The controller holds the FSM, prescaler, and expiry detection.

Test Plan (TICK_DIV=4):
- Reset then load preset 16'h0003, start: time goes 00:03 -> 00:02 -> 00:01 -> 00:00 at 4-cycle intervals (first change 4 cycles after start edge). done is high for one cycle as state becomes DONE=4, and running drops.
- Load 16'h1000, start, 4 cycles: time_bcd = 16'h0959, which checks borrow across all digits.
- Load 16'h0010, start, pause after 6 cycles (time 00:09, prescaler=2), hold 20 cycles: no change. Start: next tick after 2 more cycles gives 00:08.
- Load 16'hFA7C: time_bcd = 16'h0000 (F->0, A->0, 7->0 sec_tens, C->0), state LOADED. Start: immediate DONE with done pulse.
- In RUN at 00:05, assert load with 16'h0030: ignored. Assert clear and start in the same cycle: clear wins, giving time 0 and state IDLE.
- In RUN, assert rst for one cycle: all outputs return to reset values next edge, and done stays 0.
